// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Merges the core's instruction-fetch (imem) and data (dmem) request streams
// onto a single physical memory port (pmem).
//
// Arbitration: dmem has fixed priority. imem cannot starve: after
// MAX_D_STREAK back-to-back dmem grants taken while imem_read was pending,
// the next grant goes to imem.
//
// Each granted request is latched and held on pmem_* until pmem_resp. The
// response is then routed to the requester that was granted, and only to it.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   imem_address/read fetch request (held by the core until imem_resp)
//   imem_rdata/resp   fetch data and one-cycle completion pulse
//   dmem_address/read/write/wmask/wdata
//                     data request (held by the core until dmem_resp)
//   dmem_rdata/resp   load data and one-cycle completion pulse
//   pmem_address/read/write/wmask/wdata
//                     physical port, driven from the latched request only
//   pmem_rdata/resp   physical read data and completion
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  // Legal range 1..15 (the streak counter is 4 bits wide).
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] imem_address,
  input  logic        imem_read,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,

  input  logic [31:0] dmem_address,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,

  output logic [31:0] pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [3:0]  pmem_wmask,
  output logic [31:0] pmem_wdata,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_BUSY = 2'd1,
    ST_D_BUSY = 2'd2
  } state_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  // Saturating increment of the dmem streak counter.
  function automatic logic [3:0] streak_inc(input logic [3:0] cur);
    logic [3:0] nxt;
    if (cur >= STREAK_MAX) begin
      nxt = STREAK_MAX;
    end else begin
      nxt = cur + 4'd1;
    end
    return nxt;
  endfunction

  state_e      state_q,  state_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] addr_q,   addr_d;
  logic [3:0]  wmask_q,  wmask_d;
  logic [31:0] wdata_q,  wdata_d;
  logic        read_q,   read_d;
  logic        write_q,  write_d;

  logic        d_req;
  logic        i_starved;

  assign d_req     = dmem_read | dmem_write;
  // imem has waited through the maximum number of dmem grants: it wins next.
  assign i_starved = imem_read & (streak_q == STREAK_MAX);

  // Next-state, latched-request and streak-counter computation.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wmask_d  = wmask_q;
    wdata_d  = wdata_q;
    read_d   = read_q;
    write_d  = write_q;

    case (state_q)
      ST_IDLE: begin
        if (d_req && !i_starved) begin
          state_d = ST_D_BUSY;
          addr_d  = dmem_address;
          // A simultaneous read+write is served as a write only.
          write_d = dmem_write;
          read_d  = ~dmem_write;
          if (dmem_write) begin
            wmask_d = dmem_wmask;
            wdata_d = dmem_wdata;
          end else begin
            wmask_d = 4'h0;
            wdata_d = 32'h0000_0000;
          end
          if (imem_read) begin
            streak_d = streak_inc(streak_q);
          end else begin
            streak_d = 4'd0;
          end
        end else if (imem_read) begin
          state_d  = ST_I_BUSY;
          addr_d   = imem_address;
          read_d   = 1'b1;
          write_d  = 1'b0;
          wmask_d  = 4'h0;
          wdata_d  = 32'h0000_0000;
          streak_d = 4'd0;
        end else begin
          // Idle with no fetch pending: the streak is forgotten.
          state_d  = ST_IDLE;
          streak_d = 4'd0;
          addr_d   = 32'h0000_0000;
          wmask_d  = 4'h0;
          wdata_d  = 32'h0000_0000;
          read_d   = 1'b0;
          write_d  = 1'b0;
        end
      end

      ST_I_BUSY, ST_D_BUSY: begin
        if (pmem_resp) begin
          // Strobes drop on the next cycle; the following IDLE cycle
          // performs the next arbitration.
          state_d = ST_IDLE;
          addr_d  = 32'h0000_0000;
          wmask_d = 4'h0;
          wdata_d = 32'h0000_0000;
          read_d  = 1'b0;
          write_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        streak_d = 4'd0;
        addr_d   = 32'h0000_0000;
        wmask_d  = 4'h0;
        wdata_d  = 32'h0000_0000;
        read_d   = 1'b0;
        write_d  = 1'b0;
      end
    endcase
  end

  // State and latched-request registers; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      streak_q <= 4'd0;
      addr_q   <= 32'h0000_0000;
      wmask_q  <= 4'h0;
      wdata_q  <= 32'h0000_0000;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wmask_q  <= wmask_d;
      wdata_q  <= wdata_d;
      read_q   <= read_d;
      write_q  <= write_d;
    end
  end

  // The physical port is a direct view of the latched request.
  assign pmem_address = addr_q;
  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_wmask   = wmask_q;
  assign pmem_wdata   = wdata_q;

  // Responses are steered combinationally in the pmem_resp cycle; a
  // pmem_resp seen in IDLE matches neither busy state and is dropped.
  assign imem_resp = (state_q == ST_I_BUSY) & pmem_resp;
  assign dmem_resp = (state_q == ST_D_BUSY) & pmem_resp;

  // Read data is shared by both requesters and forced to zero in reset.
  assign imem_rdata = rst ? pmem_rdata : 32'h0000_0000;
  assign dmem_rdata = rst ? pmem_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Scoreboard bench: each test pushes the transactions it expects to see on
// the physical port (in grant order) when it drives the requests; a monitor
// pops one entry on every imem_resp/dmem_resp pulse and compares the owner,
// latched address/op/mask/data and returned read data. A simple memory model
// answers pmem strobes after a programmable number of wait cycles.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [3:0]  pmem_wmask;
  logic [31:0] pmem_wdata;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic        is_d;
    logic        is_w;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t mon_e;

  // memory model controls
  int   mem_wait = 0;
  bit   mem_en   = 1'b1;
  bit   spurious = 1'b0;
  int   wcnt     = 0;

  mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .imem_address(imem_address), .imem_read(imem_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wmask(pmem_wmask), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0060) return 32'h0000_0013;
    else return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic is_w, input logic [31:0] addr,
                          input logic [3:0] wmask, input logic [31:0] wdata);
    txn_t t;
    t.is_d = is_d; t.is_w = is_w; t.addr = addr; t.wmask = wmask; t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: answers an active strobe after mem_wait extra cycles.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = 32'hCAFE_F00D;
    forever begin
      @(posedge clk);
      #1;
      pmem_rdata = mem_data(pmem_address);
      if (spurious) begin
        pmem_resp = 1'b1;
      end else if (mem_en && (pmem_read || pmem_write)) begin
        if (wcnt >= mem_wait) begin
          pmem_resp = 1'b1;
          wcnt = 0;
        end else begin
          pmem_resp = 1'b0;
          wcnt++;
        end
      end else begin
        pmem_resp = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Scoreboard monitor: every response pulse consumes one expected entry.
  always @(negedge clk) begin
    if (imem_resp || dmem_resp) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_resp", 64'({imem_resp, dmem_resp}), 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("resp_owner", 64'({imem_resp, dmem_resp}), mon_e.is_d ? 64'h1 : 64'h2);
        check_eq("resp_addr", 64'(pmem_address), 64'(mon_e.addr));
        check_eq("resp_read", 64'(pmem_read), 64'(!mon_e.is_w));
        check_eq("resp_write", 64'(pmem_write), 64'(mon_e.is_w));
        check_eq("resp_wmask", 64'(pmem_wmask), 64'(mon_e.wmask));
        check_eq("resp_wdata", 64'(pmem_wdata), 64'(mon_e.wdata));
        check_eq("imem_rdata", 64'(imem_rdata), 64'(mem_data(mon_e.addr)));
        check_eq("dmem_rdata", 64'(dmem_rdata), 64'(mem_data(mon_e.addr)));
      end
    end
  end

  // Behaves like the core: drops a request after its resp, optionally
  // re-issuing dmem at the next address until d_keep dmem responses are seen.
  task automatic serve(input int n_resp, input int budget, input int d_keep,
                       input bit no_read, input string tag);
    int seen  = 0;
    int d_cnt = 0;
    bit i_s;
    bit d_s;
    for (int c = 0; c < budget && seen < n_resp; c++) begin
      @(negedge clk);
      i_s = imem_resp;
      d_s = dmem_resp;
      check_eq({tag, "_one_strobe"}, 64'(pmem_read & pmem_write), 64'h0);
      if (no_read) check_eq({tag, "_no_pread"}, 64'(pmem_read), 64'h0);
      if (i_s) seen++;
      if (d_s) seen++;
      step();
      if (i_s) imem_read = 1'b0;
      if (d_s) begin
        d_cnt++;
        if (d_cnt >= d_keep) begin
          dmem_read  = 1'b0;
          dmem_write = 1'b0;
        end else begin
          dmem_address = dmem_address + 32'h4;
        end
      end
    end
    check_eq({tag, "_resp_count"}, 64'(seen), 64'(n_resp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    imem_address = 32'h0; imem_read = 1'b0;
    dmem_address = 32'h0; dmem_read = 1'b0; dmem_write = 1'b0;
    dmem_wmask = 4'h0; dmem_wdata = 32'h0;

    // ---- reset: all outputs 0, even with a request and nonzero pmem_rdata
    dmem_write = 1'b1; dmem_address = 32'h0000_0ABC; dmem_wmask = 4'hF; dmem_wdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_pread",  64'(pmem_read), 64'h0);
    check_eq("rst_pwrite", 64'(pmem_write), 64'h0);
    check_eq("rst_paddr",  64'(pmem_address), 64'h0);
    check_eq("rst_pwmask", 64'(pmem_wmask), 64'h0);
    check_eq("rst_pwdata", 64'(pmem_wdata), 64'h0);
    check_eq("rst_iresp",  64'(imem_resp), 64'h0);
    check_eq("rst_dresp",  64'(dmem_resp), 64'h0);
    check_eq("rst_irdata", 64'(imem_rdata), 64'h0);
    check_eq("rst_drdata", 64'(dmem_rdata), 64'h0);
    dmem_write = 1'b0; dmem_wmask = 4'h0; dmem_wdata = 32'h0; dmem_address = 32'h0;
    step();
    rst = 1'b1;
    step();

    // ---- single fetch, resp 3 cycles after the request
    mem_wait = 2;
    imem_address = 32'h0000_0060; imem_read = 1'b1;
    push_exp(1'b0, 1'b0, 32'h0000_0060, 4'h0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("t1_pread", 64'(pmem_read), 64'(c >= 1 && c <= 3));
      check_eq("t1_paddr", 64'(pmem_address), (c >= 1 && c <= 3) ? 64'h60 : 64'h0);
      check_eq("t1_iresp", 64'(imem_resp), 64'(c == 3));
      check_eq("t1_dresp", 64'(dmem_resp), 64'h0);
      step();
      if (c == 3) imem_read = 1'b0;
    end

    // ---- masked write
    mem_wait = 1;
    dmem_address = 32'h0000_0104; dmem_wmask = 4'b0011; dmem_wdata = 32'hDEAD_BEEF; dmem_write = 1'b1;
    push_exp(1'b1, 1'b1, 32'h0000_0104, 4'b0011, 32'hDEAD_BEEF);
    serve(1, 20, 1, 1'b1, "t2");

    // ---- simultaneous requests: dmem first; its address moves while busy
    mem_wait = 2;
    imem_address = 32'h0000_0080; imem_read = 1'b1;
    dmem_address = 32'h0000_0180; dmem_read = 1'b1; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
    push_exp(1'b1, 1'b0, 32'h0000_0180, 4'h0, 32'h0);
    push_exp(1'b0, 1'b0, 32'h0000_0080, 4'h0, 32'h0);
    step();
    dmem_address = 32'h0000_01F0;
    @(negedge clk);
    check_eq("t3_paddr_hold", 64'(pmem_address), 64'h180);
    serve(2, 30, 1, 1'b0, "t3");

    // ---- starvation bound: 4 dmem grants, 1 imem, then dmem resumes
    mem_wait = 0;
    imem_address = 32'h0000_0200; imem_read = 1'b1;
    dmem_address = 32'h0000_1000; dmem_read = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(1'b1, 1'b0, 32'h0000_1000 + 32'(4 * k), 4'h0, 32'h0);
    push_exp(1'b0, 1'b0, 32'h0000_0200, 4'h0, 32'h0);
    push_exp(1'b1, 1'b0, 32'h0000_1010, 4'h0, 32'h0);
    push_exp(1'b1, 1'b0, 32'h0000_1014, 4'h0, 32'h0);
    serve(7, 60, 6, 1'b0, "t4");

    // ---- conflicting ops: read+write is a write
    mem_wait = 0;
    dmem_address = 32'h0000_0400; dmem_wmask = 4'hF; dmem_wdata = 32'h1234_5678;
    dmem_read = 1'b1; dmem_write = 1'b1;
    push_exp(1'b1, 1'b1, 32'h0000_0400, 4'hF, 32'h1234_5678);
    serve(1, 20, 1, 1'b1, "t6");

    // ---- request dropped mid-transaction still completes
    mem_wait = 3;
    dmem_address = 32'h0000_0500; dmem_wmask = 4'h0; dmem_wdata = 32'h0; dmem_read = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0000_0500, 4'h0, 32'h0);
    step();
    step();
    dmem_read = 1'b0;
    serve(1, 20, 1, 1'b0, "t7");

    // ---- reset mid-access, then a spurious pmem_resp in IDLE
    mem_en = 1'b0;
    dmem_address = 32'h0000_0300; dmem_wmask = 4'hF; dmem_wdata = 32'h1111_2222; dmem_write = 1'b1;
    step();
    step();
    @(negedge clk);
    check_eq("t5_pwrite_busy", 64'(pmem_write), 64'h1);
    check_eq("t5_paddr_busy", 64'(pmem_address), 64'h300);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t5_pwrite_rst", 64'(pmem_write), 64'h0);
    check_eq("t5_paddr_rst", 64'(pmem_address), 64'h0);
    check_eq("t5_dresp_rst", 64'(dmem_resp), 64'h0);
    dmem_write = 1'b0;
    step();
    rst = 1'b1;
    mem_en = 1'b1;
    spurious = 1'b1;
    step();
    @(negedge clk);
    check_eq("t5_spur_iresp", 64'(imem_resp), 64'h0);
    check_eq("t5_spur_dresp", 64'(dmem_resp), 64'h0);
    check_eq("t5_spur_pread", 64'(pmem_read), 64'h0);
    spurious = 1'b0;
    step();
    step();

    check_eq("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly downstream of the cpu core's imem and dmem ports.
- Merges the instruction-fetch request stream and the data (MEM-stage) request stream onto one physical memory port.
- Fixed dmem priority, with a bounded-starvation guarantee for imem.
- Latches each granted request, holds it on the physical port until pmem_resp, then routes the response back to the granted requester only.

Parameters:
- MAX_D_STREAK, 4: maximum consecutive dmem grants while imem_read is pending before imem is forced a grant. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_address  in  32  fetch address
- imem_read  in  1  fetch request; held until imem_resp
- imem_rdata  out  32  fetch data, valid with imem_resp
- imem_resp  out  1  fetch complete, one cycle
- dmem_address  in  32  data address
- dmem_read  in  1  data read request; held until dmem_resp
- dmem_write  in  1  data write request; held until dmem_resp
- dmem_wmask  in  4  byte enables for write
- dmem_wdata  in  32  write data
- dmem_rdata  out  32  read data, valid with dmem_resp
- dmem_resp  out  1  data access complete, one cycle
- pmem_address  out  32  physical memory address
- pmem_read  out  1  physical read strobe
- pmem_write  out  1  physical write strobe
- pmem_wmask  out  4  physical byte enables
- pmem_wdata  out  32  physical write data
- pmem_rdata  in  32  physical read data
- pmem_resp  in  1  physical access complete

Behaviour:

Reset:
- While rst=0, asynchronously: state=IDLE, streak counter=0, all latched request registers=0.
- All outputs are 0 during reset.
- Reset mid-transaction aborts it: pmem_read and pmem_write drop immediately, and no resp is issued afterwards.

States:
- IDLE, I_BUSY, D_BUSY.

IDLE:
- If dmem_read or dmem_write is asserted and not (imem_read && streak==MAX_D_STREAK), grant dmem:
  - latch address, wmask and wdata; latch op=write if dmem_write, else read;
  - go to D_BUSY.
- Else if imem_read is asserted, grant imem:
  - latch address; go to I_BUSY.
- Otherwise stay in IDLE.

BUSY states:
- pmem_* are driven only from the latched registers.
- pmem_read=1 for I_BUSY or a D_BUSY read.
- pmem_write=1 for a D_BUSY write.
- For reads, pmem_wmask and pmem_wdata are 0.
- Stay in the BUSY state until pmem_resp=1.

Response cycle (pmem_resp=1 while BUSY):
- The granted requester's resp output is asserted combinationally in that same cycle, for exactly one cycle.
- Next state is IDLE; pmem strobes deassert on the following cycle.
- imem_rdata and dmem_rdata both carry pmem_rdata at all times; only the resp signals are gated.

Latency:
- A request seen in IDLE at cycle N drives pmem strobes from cycle N+1.
- Zero-wait memory: resp at N+1, next grant decision at N+2.
- Minimum turnaround is 2 cycles per access.

Streak counter (4 bits):
- On a dmem grant with imem_read=1: increment, saturating at MAX_D_STREAK.
- On an imem grant, or in any IDLE cycle with imem_read=0: clear to 0.

Boundary conditions:
- dmem_read and dmem_write both 1: treated as a write; the read is ignored.
- pmem_resp asserted in IDLE: ignored; no resp output.
- A requester dropping its request mid-transaction: the transaction still completes and resp is still pulsed.
- Requester input changes while BUSY have no effect on pmem_*, because the request is latched.
- Both requesters asserted in the same cycle as a response: the new arbitration happens in the IDLE cycle that follows, never in the response cycle.

Test Plan:
- Single fetch: imem_read=1, imem_address=0x60 at cycle 0; pmem_resp=1, pmem_rdata=0x00000013 at cycle 3 -> pmem_read=1, pmem_address=0x60 on cycles 1–3; imem_resp=1, imem_rdata=0x13 at cycle 3 only; dmem_resp stays 0.
- Write with mask: dmem_write=1, dmem_address=0x104, dmem_wmask=0b0011, dmem_wdata=0xDEADBEEF -> pmem_write=1 with identical address/mask/data until resp; pmem_read stays 0; dmem_resp pulses once.
- Simultaneous requests: imem_read and dmem_read both asserted at cycle 0 -> dmem served first, imem served on the next IDLE, each resp pulsed once; input address changes during D_BUSY do not alter pmem_address.
- Starvation bound: MAX_D_STREAK=4, imem_read held, dmem reissues every cycle, zero-wait memory -> exactly 4 dmem grants, then 1 imem grant, then dmem resumes.
- Reset mid-access: rst=0 during D_BUSY, before pmem_resp -> pmem_write=0 immediately, no dmem_resp; after release, a spurious pmem_resp in IDLE produces no resp.
- Conflicting ops: dmem_read=1 and dmem_write=1 -> only pmem_write asserted; single dmem_resp.
